uart_tx_fifo_sender: RTL and testbench

- Byte buffer and transmit sequencer directly upstream of the UART top's transmitter.
- Accepts bursts of bytes from a producer (e.g. a message formatter or an RX echo path) into a circular FIFO.
- Feeds bytes one at a time into the UART TX data/start inputs, pacing on the transmitter's busy flag so no byte is lost or overwritten mid-frame.

---
 rtl/uart_tx_fifo_sender.sv | 115 +++++++++++
 tb/tb_uart_tx_fifo_sender.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_sender.sv
// Circular byte FIFO feeding a UART transmitter one byte at a time.
// Each pop raises a one-cycle start pulse; the next pop waits until the transmitter's busy flag settles.
module uart_tx_fifo_sender #(
    parameter int DEPTH        = 8,
    parameter int ADDR_W       = 3,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [7:0]        i_push_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow,
    input  logic              i_tx_busy,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_start
);

    localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    state_t            state;
    state_t            state_nxt;
    logic [TW-1:0]     tmo;
    logic [TW-1:0]     tmo_nxt;
    logic              push_ok;
    logic              pop;

    assign o_count = count;
    assign o_full  = (count == (ADDR_W+1)'(DEPTH));
    assign o_empty = (count == '0);
    assign push_ok = i_push && !o_full;

    always_comb begin
        state_nxt = state;
        tmo_nxt   = tmo;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!o_empty && !i_tx_busy) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                tmo_nxt   = '0;
                state_nxt = i_tx_busy ? WAIT_DONE : WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A transmitter that never raises busy must not stall the queue.
                if (i_tx_busy)
                    state_nxt = WAIT_DONE;
                else if (tmo == TMO_LAST)
                    state_nxt = IDLE;
                else
                    tmo_nxt = tmo + 1'b1;
            end
            WAIT_DONE: begin
                if (!i_tx_busy)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tmo        <= '0;
            rd_ptr     <= '0;
            o_tx_start <= 1'b0;
            o_tx_data  <= 8'h00;
        end else begin
            state      <= state_nxt;
            tmo        <= tmo_nxt;
            o_tx_start <= pop;
            if (pop) begin
                o_tx_data <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= i_push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (i_push && o_full)
                o_overflow <= 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_sender.sv
// Directed and randomized checks of the UART TX FIFO sender against a queue-based reference
// model and a simple transmitter busy-flag model.
module tb_uart_tx_fifo_sender;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int BT     = 4;

    logic              clk;
    logic              reset;
    logic              i_push;
    logic [7:0]        i_push_data;
    logic              o_full;
    logic              o_empty;
    logic [ADDR_W:0]   o_count;
    logic              o_overflow;
    logic              i_tx_busy;
    logic [7:0]        o_tx_data;
    logic              o_tx_start;

    uart_tx_fifo_sender #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .reset(reset), .i_push(i_push), .i_push_data(i_push_data),
        .o_full(o_full), .o_empty(o_empty), .o_count(o_count), .o_overflow(o_overflow),
        .i_tx_busy(i_tx_busy), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          last_start = -100;
    int          n_starts = 0;
    int          max_count = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  sent[$];
    int          start_cyc[$];
    logic        m_over = 1'b0;
    logic [7:0]  last_data = 8'h00;
    // transmitter model: 0 = responsive, 1 = dead (busy never rises), 2 = busy held high
    int          tx_mode = 0;
    logic        arm = 1'b0;
    int          busy_left = 0;
    int          frame_len = 3;
    int          fixed_len = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic push, input logic [7:0] data);
        int   pre_n;
        logic pre_busy;
        logic popped;
        logic [7:0] front;
        i_push      = push;
        i_push_data = data;
        if (tx_mode == 1)      i_tx_busy = 1'b0;
        else if (tx_mode == 2) i_tx_busy = 1'b1;
        else if (arm) begin
            i_tx_busy = 1'b0;
            arm       = 1'b0;
            busy_left = frame_len;
        end else if (busy_left > 0) begin
            i_tx_busy = 1'b1;
            busy_left--;
        end else i_tx_busy = 1'b0;
        pre_n    = exp_q.size();
        pre_busy = i_tx_busy;
        @(posedge clk);
        #1;
        cyc++;
        popped = o_tx_start;
        if (popped === 1'b1) begin
            chk("pop_needs_data", 32'(pre_n > 0), 1);
            chk("pop_needs_idle_tx", 32'(pre_busy), 0);
            chk("start_gap_ge3", 32'((cyc - last_start) >= 3), 1);
            front = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            chk("tx_data_order", 32'(o_tx_data), 32'(front));
            sent.push_back(o_tx_data);
            start_cyc.push_back(cyc);
            last_start = cyc;
            last_data  = o_tx_data;
            n_starts++;
            arm       = (tx_mode == 0);
            frame_len = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 6));
        end else begin
            chk("tx_data_stable", 32'(o_tx_data), 32'(last_data));
        end
        if (push && pre_n < DEPTH) exp_q.push_back(data);
        if (push && pre_n == DEPTH) m_over = 1'b1;
        chk("count", 32'(o_count), 32'(exp_q.size()));
        chk("empty", 32'(o_empty), 32'(exp_q.size() == 0));
        chk("full", 32'(o_full), 32'(exp_q.size() == DEPTH));
        chk("overflow", 32'(o_overflow), 32'(m_over));
        if (int'(o_count) > max_count) max_count = int'(o_count);
    endtask

    task automatic model_reset();
        exp_q.delete();
        sent.delete();
        start_cyc.delete();
        m_over     = 1'b0;
        last_data  = 8'h00;
        last_start = -100;
        n_starts   = 0;
        arm        = 1'b0;
        busy_left  = 0;
        fixed_len  = 0;
        max_count  = 0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        i_push    = 1'b0;
        i_tx_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step(1'b0, 8'h00);
        chk("drain_timeout", 32'(exp_q.size()), 0);
        repeat (15) step(1'b0, 8'h00);
    endtask

    initial begin
        reset = 1'b1; i_push = 1'b0; i_push_data = 8'h00; i_tx_busy = 1'b0;
        do_reset();

        chk("rst_count", 32'(o_count), 0);
        chk("rst_empty", 32'(o_empty), 1);
        chk("rst_full", 32'(o_full), 0);
        chk("rst_overflow", 32'(o_overflow), 0);
        chk("rst_tx_data", 32'(o_tx_data), 0);
        chk("rst_tx_start", 32'(o_tx_start), 0);

        // single byte: start pulse exactly two edges after the push edge
        tx_mode = 0;
        step(1'b1, 8'h41);
        chk("lat_no_start_on_push", 32'(o_tx_start), 0);
        step(1'b0, 8'h00);
        chk("lat_start_2_edges", 32'(o_tx_start), 1);
        chk("lat_data", 32'(o_tx_data), 32'h41);
        repeat (10) step(1'b0, 8'h00);
        chk("single_one_pulse", 32'(n_starts), 1);
        chk("single_empty_after", 32'(o_empty), 1);

        // fill while transmitter busy, then overflow
        do_reset();
        tx_mode = 2;
        for (int i = 0; i < 8; i++) step(1'b1, 8'h30 + 8'(i));
        chk("full_after_8", 32'(o_full), 1);
        step(1'b1, 8'hFF);
        chk("overflow_set", 32'(o_overflow), 1);
        chk("overflow_count", 32'(o_count), 8);
        tx_mode = 0;
        drain(200);
        chk("fill_sent_n", 32'(sent.size()), 8);
        for (int i = 0; i < sent.size(); i++) chk("fill_order", 32'(sent[i]), 32'h30 + 32'(i));
        chk("overflow_sticky", 32'(o_overflow), 1);

        // random stream of 12 bytes while draining; pointers wrap
        do_reset();
        tx_mode = 0;
        for (int n = 0; n < 12; ) begin
            if ($urandom_range(0, 1) == 1 && exp_q.size() < DEPTH) begin
                step(1'b1, 8'($urandom));
                n++;
            end else step(1'b0, 8'h00);
        end
        drain(300);
        chk("stream_sent_n", 32'(sent.size()), 12);
        chk("stream_max_count", 32'(max_count <= DEPTH), 1);
        chk("stream_no_overflow", 32'(o_overflow), 0);

        // simultaneous push and pop with three entries queued
        tx_mode = 2;
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom));
        tx_mode = 0;
        step(1'b1, 8'hA5);
        chk("same_cycle_start", 32'(o_tx_start), 1);
        chk("same_cycle_count", 32'(o_count), 3);
        drain(200);

        // dead transmitter: busy never asserts
        do_reset();
        tx_mode = 1;
        step(1'b1, 8'h5A);
        step(1'b1, 8'hC3);
        drain(100);
        chk("dead_sent_n", 32'(sent.size()), 2);
        if (start_cyc.size() == 2)
            chk("dead_gap", 32'(start_cyc[1] - start_cyc[0]), 32'(BT + 2));

        // reset while the transmitter is mid-frame with five bytes queued
        do_reset();
        tx_mode   = 0;
        fixed_len = 30;
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom));
        repeat (3) step(1'b0, 8'h00);
        chk("pre_reset_count", 32'(o_count), 5);
        chk("pre_reset_busy", 32'(i_tx_busy), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_count", 32'(o_count), 0);
        chk("async_rst_empty", 32'(o_empty), 1);
        chk("async_rst_tx_data", 32'(o_tx_data), 0);
        chk("async_rst_tx_start", 32'(o_tx_start), 0);
        chk("async_rst_overflow", 32'(o_overflow), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        i_tx_busy = 1'b0;
        repeat (15) step(1'b0, 8'h00);
        chk("post_reset_no_start", 32'(n_starts), 0);
        step(1'b1, 8'h77);
        step(1'b0, 8'h00);
        chk("post_reset_new_push", 32'(o_tx_start), 1);
        drain(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
